// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the OF/EX bundle.
package cpu_pkg;
  localparam int CPU_DATA_W = 16;
  localparam int CPU_RA_W   = 3;
  localparam int OPC_W      = 4;

  // Opcode encoding shared by the decoder, OF and EX.
  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_SLL  = 4'h6,
    OP_SRL  = 4'h7,
    OP_ADDI = 4'h8,
    OP_LD   = 4'h9,
    OP_ST   = 4'hA,
    OP_BEQ  = 4'hB,
    OP_JAL  = 4'hC
  } opcode_e;

  // Contents of the OF/EX pipeline register.
  typedef struct packed {
    logic                  valid;
    logic                  wr_en;
    logic                  is_load;
    logic [OPC_W-1:0]      opcode;
    logic [CPU_RA_W-1:0]   rd;
    logic [CPU_DATA_W-1:0] op_a;
    logic [CPU_DATA_W-1:0] op_b;
    logic [CPU_DATA_W-1:0] imm;
  } of_ex_t;

  // True when a stage that writes rd targets the given source register.
  function automatic logic ra_hit(input logic wr_en,
                                  input logic [CPU_RA_W-1:0] rd,
                                  input logic [CPU_RA_W-1:0] src);
    return wr_en && (rd == src);
  endfunction
endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: EX > MEM > WB > register-file data.
module operand_bypass_mux #(
  parameter int DATA_W = 16,
  parameter int RA_W   = 3
) (
  input  logic [RA_W-1:0]   src_addr,
  input  logic              ex_wr_en,
  input  logic              ex_is_load,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_wr_en,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_wr_en,
  input  logic [RA_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] operand
);
  // A load in EX has no result yet; hazard logic stalls instead of forwarding it.
  always_comb begin
    operand = rf_data;
    if (ex_wr_en && !ex_is_load && (ex_rd == src_addr))
      operand = ex_result;
    else if (mem_wr_en && (mem_rd == src_addr))
      operand = mem_result;
    else if (wb_wr_en && (wb_rd == src_addr))
      operand = wb_data;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register-file read, bypass, load-use stall, OF/EX register.
module operand_fetch_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int RA_W   = CPU_RA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  input  logic [OPC_W-1:0]    in_opcode,
  input  logic [RA_W-1:0]     in_rd,
  input  logic [RA_W-1:0]     in_rs1,
  input  logic [RA_W-1:0]     in_rs2,
  input  logic                in_use_rs1,
  input  logic                in_use_rs2,
  input  logic                in_wr_en,
  input  logic                in_is_load,
  input  logic [DATA_W-1:0]   in_imm,
  output logic [2*RA_W-1:0]   reg_read_addr,
  input  logic [2*DATA_W-1:0] reg_read_data,
  input  logic                ex_wr_en,
  input  logic                ex_is_load,
  input  logic [RA_W-1:0]     ex_rd,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                mem_wr_en,
  input  logic [RA_W-1:0]     mem_rd,
  input  logic [DATA_W-1:0]   mem_result,
  input  logic                wb_wr_en,
  input  logic [RA_W-1:0]     wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                flush,
  input  logic                hold,
  output logic                stall,
  output logic                out_valid,
  output logic                out_wr_en,
  output logic                out_is_load,
  output logic [OPC_W-1:0]    out_opcode,
  output logic [RA_W-1:0]     out_rd,
  output logic [DATA_W-1:0]   out_op_a,
  output logic [DATA_W-1:0]   out_op_b,
  output logic [DATA_W-1:0]   out_imm
);
  // Lane 1 carries rs1 (upper half of the packed buses), lane 0 carries rs2.
  logic [1:0][RA_W-1:0]   src_addr;
  logic [1:0][DATA_W-1:0] rf_data;
  logic [1:0][DATA_W-1:0] opnd;
  logic                   load_use;
  of_ex_t                 ofex_d, ofex_q;

  assign src_addr      = {in_rs1, in_rs2};
  assign reg_read_addr = src_addr;
  assign rf_data       = reg_read_data;

  for (genvar g = 0; g < 2; g++) begin : g_byp
    operand_bypass_mux #(.DATA_W(DATA_W), .RA_W(RA_W)) u_byp (
      .src_addr  (src_addr[g]),
      .ex_wr_en  (ex_wr_en),
      .ex_is_load(ex_is_load),
      .ex_rd     (ex_rd),
      .ex_result (ex_result),
      .mem_wr_en (mem_wr_en),
      .mem_rd    (mem_rd),
      .mem_result(mem_result),
      .wb_wr_en  (wb_wr_en),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .rf_data   (rf_data[g]),
      .operand   (opnd[g])
    );
  end

  // Load in EX feeding a source we read: wait one cycle for MEM to forward it.
  always_comb begin
    load_use = in_valid && ex_is_load &&
               ((in_use_rs1 && ra_hit(ex_wr_en, ex_rd, in_rs1)) ||
                (in_use_rs2 && ra_hit(ex_wr_en, ex_rd, in_rs2)));
    stall    = (load_use || hold) && !flush;
  end

  // Next OF/EX contents: hold freezes, flush/load-use inject a bubble.
  always_comb begin
    ofex_d = ofex_q;
    if (!hold) begin
      if (flush || load_use) begin
        ofex_d = '0;
      end else begin
        ofex_d.valid   = in_valid;
        ofex_d.wr_en   = in_wr_en;
        ofex_d.is_load = in_is_load;
        ofex_d.opcode  = in_opcode;
        ofex_d.rd      = in_rd;
        ofex_d.op_a    = opnd[1];
        ofex_d.op_b    = opnd[0];
        ofex_d.imm     = in_imm;
      end
    end
  end

  // OF/EX pipeline register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!resetn) ofex_q <= '0;
    else         ofex_q <= ofex_d;
  end

  assign out_valid   = ofex_q.valid;
  assign out_wr_en   = ofex_q.wr_en;
  assign out_is_load = ofex_q.is_load;
  assign out_opcode  = ofex_q.opcode;
  assign out_rd      = ofex_q.rd;
  assign out_op_a    = ofex_q.op_a;
  assign out_op_b    = ofex_q.op_b;
  assign out_imm     = ofex_q.imm;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed test-plan steps then random traffic,
// each cycle compared against a behavioural model with a register-file array.
module tb_operand_fetch_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, in_valid, in_use_rs1, in_use_rs2, in_wr_en, in_is_load;
  logic [3:0]  in_opcode;
  logic [2:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] in_imm;
  logic [5:0]  reg_read_addr;
  logic [31:0] reg_read_data;
  logic        ex_wr_en, ex_is_load, mem_wr_en, wb_wr_en, flush, hold, stall;
  logic [2:0]  ex_rd, mem_rd, wb_rd;
  logic [15:0] ex_result, mem_result, wb_data;
  logic        out_valid, out_wr_en, out_is_load;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [15:0] out_op_a, out_op_b, out_imm;

  // Register file: combinational read, returns 0 during reset.
  logic [15:0] regs [8];
  assign reg_read_data = resetn ? {regs[reg_read_addr[5:3]], regs[reg_read_addr[2:0]]} : 32'h0;

  operand_fetch_stage dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1),
    .in_use_rs2(in_use_rs2), .in_wr_en(in_wr_en), .in_is_load(in_is_load),
    .in_imm(in_imm), .reg_read_addr(reg_read_addr), .reg_read_data(reg_read_data),
    .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
    .mem_wr_en(mem_wr_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .hold(hold), .stall(stall),
    .out_valid(out_valid), .out_wr_en(out_wr_en), .out_is_load(out_is_load),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_op_a(out_op_a),
    .out_op_b(out_op_b), .out_imm(out_imm)
  );

  int nvec = 0;
  int nerr = 0;

  // Expected OF/EX register contents.
  logic        m_valid, m_wr_en, m_is_load;
  logic [3:0]  m_opcode;
  logic [2:0]  m_rd;
  logic [15:0] m_a, m_b, m_imm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Source value as the spec's priority list describes it.
  function automatic logic [15:0] fwd(input logic [2:0] a);
    if (ex_wr_en && !ex_is_load && ex_rd == a) return ex_result;
    if (mem_wr_en && mem_rd == a)              return mem_result;
    if (wb_wr_en && wb_rd == a)                return wb_data;
    return regs[a];
  endfunction

  // One cycle: check combinational outputs, advance model, check registers.
  task automatic step();
    logic lu, st;
    logic [15:0] a, b;
    #1;
    lu = in_valid && ex_wr_en && ex_is_load &&
         ((in_use_rs1 && ex_rd == in_rs1) || (in_use_rs2 && ex_rd == in_rs2));
    st = (lu || hold) && !flush;
    a  = fwd(in_rs1);
    b  = fwd(in_rs2);
    check("read_addr", {26'd0, reg_read_addr}, {26'd0, in_rs1, in_rs2});
    check("stall", {31'd0, stall}, {31'd0, st});
    if (!resetn) begin
      {m_valid, m_wr_en, m_is_load, m_opcode, m_rd, m_a, m_b, m_imm} = '0;
    end else if (hold) begin
      // frozen
    end else if (flush || lu) begin
      {m_valid, m_wr_en, m_is_load, m_opcode, m_rd, m_a, m_b, m_imm} = '0;
    end else begin
      m_valid = in_valid; m_wr_en = in_wr_en; m_is_load = in_is_load;
      m_opcode = in_opcode; m_rd = in_rd; m_a = a; m_b = b; m_imm = in_imm;
    end
    @(posedge clk);
    #1;
    if (resetn && wb_wr_en) regs[wb_rd] = wb_data;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_wr_en", {31'd0, out_wr_en}, {31'd0, m_wr_en});
    check("out_is_load", {31'd0, out_is_load}, {31'd0, m_is_load});
    check("out_opcode", {28'd0, out_opcode}, {28'd0, m_opcode});
    check("out_rd", {29'd0, out_rd}, {29'd0, m_rd});
    check("out_op_a", {16'd0, out_op_a}, {16'd0, m_a});
    check("out_op_b", {16'd0, out_op_b}, {16'd0, m_b});
    check("out_imm", {16'd0, out_imm}, {16'd0, m_imm});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_use_rs1 = 1'b1; in_use_rs2 = 1'b1; in_wr_en = 1'b1; in_is_load = 1'b0;
    in_imm = 16'h0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    resetn = 1'b0; flush = 1'b0; hold = 1'b0;
    in_valid = 0; in_opcode = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0;
    in_use_rs1 = 0; in_use_rs2 = 0; in_wr_en = 0; in_is_load = 0; in_imm = 0;
    ex_wr_en = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
    mem_wr_en = 0; mem_rd = 0; mem_result = 0;
    wb_wr_en = 0; wb_rd = 0; wb_data = 0;
    {m_valid, m_wr_en, m_is_load, m_opcode, m_rd, m_a, m_b, m_imm} = '0;
    @(negedge clk);

    // Reset state
    step();
    check("reset_valid", {31'd0, out_valid}, 32'd0);

    // No hazard: ADD r3 = r1, r2
    resetn = 1'b1;
    regs[1] = 16'h0011; regs[2] = 16'h0022;
    set_instr(OP_ADD, 3'd3, 3'd1, 3'd2);
    step();
    check("tp_addr", {26'd0, reg_read_addr}, 32'b001_010);
    check("tp_op_a", {16'd0, out_op_a}, 32'h0011);
    check("tp_op_b", {16'd0, out_op_b}, 32'h0022);
    check("tp_valid", {31'd0, out_valid}, 32'd1);

    // Forwarding priority on rs1
    ex_wr_en = 1; ex_rd = 1; ex_result = 16'hAAAA;
    mem_wr_en = 1; mem_rd = 1; mem_result = 16'hBBBB;
    wb_wr_en = 1; wb_rd = 1; wb_data = 16'hCCCC;
    step();
    check("prio_ex", {16'd0, out_op_a}, 32'hAAAA);
    ex_wr_en = 0;
    step();
    check("prio_mem", {16'd0, out_op_a}, 32'hBBBB);
    mem_wr_en = 0;
    step();
    check("prio_wb", {16'd0, out_op_a}, 32'hCCCC);
    wb_wr_en = 0;

    // Load-use on rs2: one bubble, then MEM forwards the load data
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 2;
    set_instr(OP_ADD, 3'd4, 3'd1, 3'd2);
    #1 check("lu_stall", {31'd0, stall}, 32'd1);
    step();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_rd = 2; mem_result = 16'h1234;
    #1 check("lu_nostall", {31'd0, stall}, 32'd0);
    step();
    check("lu_fwd", {16'd0, out_op_b}, 32'h1234);
    mem_wr_en = 0;

    // Flush concurrent with load-use
    ex_wr_en = 1; ex_is_load = 1; ex_rd = 1; flush = 1;
    #1 check("fl_stall", {31'd0, stall}, 32'd0);
    step();
    check("fl_bubble", {31'd0, out_valid}, 32'd0);
    flush = 0; ex_wr_en = 0; ex_is_load = 0;
    #1 check("fl_after", {31'd0, stall}, 32'd0);
    step();

    // Hold for three cycles
    regs[4] = 16'h5555;
    set_instr(OP_SUB, 3'd5, 3'd4, 3'd2);
    step();
    hold = 1;
    set_instr(OP_XOR, 3'd6, 3'd1, 3'd3);
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", {31'd0, stall}, 32'd1);
      step();
      check("hold_op_a", {16'd0, out_op_a}, 32'h5555);
    end
    hold = 0;
    step();
    check("hold_release_rd", {29'd0, out_rd}, 32'd6);

    // Reset while holding a valid instruction
    hold = 1; resetn = 0;
    step();
    check("rst_hold_valid", {31'd0, out_valid}, 32'd0);
    check("rst_hold_op_a", {16'd0, out_op_a}, 32'd0);
    hold = 0; resetn = 1;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      resetn     = ($urandom_range(0, 39) != 0);
      in_valid   = $urandom_range(0, 1);
      in_opcode  = 4'($urandom);
      in_rd      = 3'($urandom);
      in_rs1     = 3'($urandom);
      in_rs2     = 3'($urandom);
      in_use_rs1 = $urandom_range(0, 1);
      in_use_rs2 = $urandom_range(0, 1);
      in_wr_en   = $urandom_range(0, 1);
      in_is_load = $urandom_range(0, 1);
      in_imm     = 16'($urandom);
      ex_wr_en   = $urandom_range(0, 1);
      ex_is_load = ($urandom_range(0, 3) == 0);
      ex_rd      = 3'($urandom);
      ex_result  = 16'($urandom);
      mem_wr_en  = $urandom_range(0, 1);
      mem_rd     = 3'($urandom);
      mem_result = 16'($urandom);
      wb_wr_en   = $urandom_range(0, 1);
      wb_rd      = 3'($urandom);
      wb_data    = 16'($urandom);
      flush      = ($urandom_range(0, 7) == 0);
      hold       = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
